// File: rtl/product_accumulator.sv
// Sums COUNT unsigned products per batch and presents the sum with an overflow flag.
// Optional build macro SATURATE_EN clamps the running sum at all-ones instead of wrapping.
module product_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int COUNT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    localparam int CNT_W = $clog2(COUNT + 1);
`ifdef SATURATE_EN
    localparam bit SAT_MODE = 1'b1;
`else
    localparam bit SAT_MODE = 1'b0;
`endif

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic               out_ovf_q, out_ovf_d;

    logic               accept;
    logic               last;
    logic [ACC_W:0]     add_full;
    logic [ACC_W-1:0]   add_res;
    logic               add_ovf;

    // One extra bit on top of the accumulator captures the carry out.
    function automatic logic [ACC_W:0] add_ext(input logic [ACC_W-1:0] acc,
                                               input logic [PROD_W-1:0] prod);
        return {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    endfunction

    function automatic logic [ACC_W-1:0] sat_sum(input logic [ACC_W-1:0] sum,
                                                 input logic carry);
        return (SAT_MODE && carry) ? {ACC_W{1'b1}} : sum;
    endfunction

    assign add_full = add_ext(acc_q, in_product);
    assign add_res  = sat_sum(add_full[ACC_W-1:0], add_full[ACC_W]);
    assign add_ovf  = ovf_q | add_full[ACC_W];
    assign accept   = in_valid && (state_q == ACCUM);
    assign last     = (cnt_q == CNT_W'(COUNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            sum_q     <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            sum_q     <= sum_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    // Clear overrides everything, including an accept or a result handoff in the same cycle.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        sum_d     = sum_q;
        out_ovf_d = out_ovf_q;
        if (clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        if (last) begin
                            sum_d     = add_res;
                            out_ovf_d = add_ovf;
                            acc_d     = '0;
                            cnt_d     = '0;
                            ovf_d     = 1'b0;
                            state_d   = HOLD;
                        end else begin
                            acc_d = add_res;
                            cnt_d = cnt_q + CNT_W'(1);
                            ovf_d = add_ovf;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    // in_ready is gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        in_ready  = rst_n && (state_q == ACCUM);
        out_valid = (state_q == HOLD);
        out_sum   = sum_q;
        out_ovf   = out_ovf_q;
    end

endmodule
